// File: rtl/alu_result_uart_packer.sv
// Captures ALU result words into a one-deep hold buffer and streams them to a
// UART transmitter one byte at a time, LSB first, using TX_BUSY as flow control.
module alu_result_uart_packer #(
  parameter int Width = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] ALU_OUT,
  input  logic             ALU_OUT_VALID,
  output logic             ALU_READY,
  output logic [7:0]       TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_BUSY,
  output logic             FRAME_DONE,
  output logic             OVERFLOW
);

  localparam int NUM_BYTES = Width / 8;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             holdFull_q, holdFull_d;
  logic [Width-1:0] holdWord_q, holdWord_d;
  logic [Width-1:0] shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
  logic [7:0]       txData_q, txData_d;
  logic             txValid_q, txValid_d;
  logic             frameDone_q, frameDone_d;
  logic             overflow_q, overflow_d;

  logic             acceptWord;
  logic             dropWord;
  logic             drainHold;
  logic             lastByte;
  logic [Width-1:0] shiftedWord;

  // A word offered while the buffer is full is lost, even on the drain edge.
  assign acceptWord  = ALU_OUT_VALID && !holdFull_q;
  assign dropWord    = ALU_OUT_VALID && holdFull_q;
  assign drainHold   = (state_q == IDLE) && holdFull_q;
  assign lastByte    = (byteCnt_q == LAST_BYTE);
  assign shiftedWord = shiftReg_q >> 8;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      holdFull_q  <= 1'b0;
      holdWord_q  <= '0;
      shiftReg_q  <= '0;
      byteCnt_q   <= '0;
      txData_q    <= 8'h00;
      txValid_q   <= 1'b0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdFull_q  <= holdFull_d;
      holdWord_q  <= holdWord_d;
      shiftReg_q  <= shiftReg_d;
      byteCnt_q   <= byteCnt_d;
      txData_q    <= txData_d;
      txValid_q   <= txValid_d;
      frameDone_q <= frameDone_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (holdFull_q) state_d = SEND;
      SEND:      if (!TX_BUSY) state_d = WAIT_BUSY;
      WAIT_BUSY: if (TX_BUSY) state_d = WAIT_IDLE;
      WAIT_IDLE: if (!TX_BUSY) state_d = lastByte ? IDLE : SEND;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    holdFull_d  = holdFull_q;
    holdWord_d  = holdWord_q;
    shiftReg_d  = shiftReg_q;
    byteCnt_d   = byteCnt_q;
    txData_d    = txData_q;
    txValid_d   = txValid_q;
    frameDone_d = 1'b0;
    overflow_d  = overflow_q | dropWord;

    if (acceptWord) begin
      holdFull_d = 1'b1;
      holdWord_d = ALU_OUT;
    end else if (drainHold) begin
      holdFull_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (holdFull_q) begin
          shiftReg_d = holdWord_q;
          byteCnt_d  = '0;
          txData_d   = holdWord_q[7:0];
          txValid_d  = 1'b1;
        end
      end
      SEND: begin
        if (!TX_BUSY) txValid_d = 1'b0;
      end
      WAIT_IDLE: begin
        if (!TX_BUSY) begin
          if (lastByte) begin
            frameDone_d = 1'b1;
          end else begin
            byteCnt_d  = byteCnt_q + CNT_W'(1);
            shiftReg_d = shiftedWord;
            txData_d   = shiftedWord[7:0];
            txValid_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ALU_READY  = !holdFull_q;
  assign TX_P_DATA  = txData_q;
  assign TX_D_VLD   = txValid_q;
  assign FRAME_DONE = frameDone_q;
  assign OVERFLOW   = overflow_q;

endmodule
